// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Valid/ready pipeline stage buffer placed between two pipeline stages.
// SKID=0 builds a single-entry pass register whose in_ready is a
// combinational function of out_ready. SKID=1 builds a two-entry skid buffer
// whose in_ready comes straight from a flop, which breaks the ready path
// between the stages. Both modes have a minimum latency of one cycle and
// sustain one transfer per cycle when downstream is always ready.
//
// Parameters
//   WIDTH       payload width in bits (1..1024)
//   SKID        0: single pass register, 1: two-entry skid buffer
//   RESET_DATA  value shown on out_data whenever the buffer is empty
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset; dominates everything
//   flush      discard all held entries and any accept in the same cycle
//   in_valid   upstream offers in_data
//   in_ready   buffer accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid entry
//   out_ready  downstream consumes out_data this cycle
//   out_data   oldest held payload, RESET_DATA when empty
//   count      number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic accept;
  logic pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  if (SKID == 0) begin : g_pass
    // -------------------------------------------------------------------------
    // Single-entry pass register.
    // -------------------------------------------------------------------------
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        // Data is left in place; only the valid bit is dropped.
        valid_d = 1'b0;
      end else if (accept) begin
        // Covers both accept alone and accept with a simultaneous pop.
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    // Payload storage needs no reset: it is masked while empty.
    always_ff @(posedge clk) begin
      data_q <= data_d;
    end

    // Combinational ready: a draining entry frees the slot in the same cycle.
    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = valid_q ? data_q : RESET_DATA;
    assign count     = {1'b0, valid_q};

  end else begin : g_skid
    // -------------------------------------------------------------------------
    // Two-entry skid buffer. head_q is always the oldest entry; skid_q only
    // holds data in StFull and is promoted to the head on the next pop.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (accept) begin
              state_d = StOne;
              head_d  = in_data;
            end
          end
          StOne: begin
            if (accept && pop) begin
              // Head drains while the new payload takes its place.
              head_d = in_data;
            end else if (accept) begin
              state_d = StFull;
              skid_d  = in_data;
            end else if (pop) begin
              state_d = StEmpty;
            end
          end
          StFull: begin
            // in_ready is low here, so only a pop can happen.
            if (pop) begin
              state_d = StOne;
              head_d  = skid_q;
            end
          end
          default: begin
            state_d = StEmpty;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StEmpty;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        // Registered copy of (next state != StFull): no path from out_ready.
        ready_q <= (state_d != StFull);
      end
    end

    always_ff @(posedge clk) begin
      head_q <= head_d;
      skid_q <= skid_d;
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = (state_q != StEmpty) ? head_q : RESET_DATA;

    always_comb begin
      count = 2'd0;
      case (state_q)
        StOne:   count = 2'd1;
        StFull:  count = 2'd2;
        default: count = 2'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interface invariants.
  // ---------------------------------------------------------------------------
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    (count != 2'd3) && ((SKID != 0) || (count != 2'd2)));

  // An offered but unconsumed entry must stay put until popped.
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush && !rst) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Drives one SKID=1 and one SKID=0 instance (WIDTH=8) with directed vectors,
// then a random valid/ready/flush phase checked against a queue model.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam logic [7:0] RstData = 8'hEE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // SKID=1 instance
  logic       s_flush, s_in_valid, s_out_ready;
  logic [7:0] s_in_data;
  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [1:0] s_count;
  // SKID=0 instance
  logic       p_flush, p_in_valid, p_out_ready;
  logic [7:0] p_in_data;
  logic       p_in_ready, p_out_valid;
  logic [7:0] p_out_data;
  logic [1:0] p_count;

  pipe_stage_buf #(
    .WIDTH      (8),
    .SKID       (1),
    .RESET_DATA (RstData)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .count     (s_count)
  );

  pipe_stage_buf #(
    .WIDTH      (8),
    .SKID       (0),
    .RESET_DATA (RstData)
  ) u_pass (
    .clk       (clk),
    .rst       (rst),
    .flush     (p_flush),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .in_data   (p_in_data),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .out_data  (p_out_data),
    .count     (p_count)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered outputs of the SKID=1 instance.
  task automatic check_s(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] c, input logic r);
    check({tag, "_valid"}, 32'(s_out_valid), 32'(v));
    check({tag, "_data"},  32'(s_out_data),  32'(d));
    check({tag, "_count"}, 32'(s_count),     32'(c));
    check({tag, "_ready"}, 32'(s_in_ready),  32'(r));
  endtask

  task automatic check_p(input string tag, input logic v, input logic [7:0] d,
                         input logic [1:0] c);
    check({tag, "_valid"}, 32'(p_out_valid), 32'(v));
    check({tag, "_data"},  32'(p_out_data),  32'(d));
    check({tag, "_count"}, 32'(p_count),     32'(c));
  endtask

  logic [7:0] sq[$];
  logic [7:0] pq[$];
  logic       s_rdy_exp, p_rdy_exp, s_acc, s_pop, p_acc, p_pop;

  initial begin
    rst = 1'b1;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = 8'h00;
    p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0; p_in_data = 8'h00;
    tick();
    tick();
    check_s("rst_s", 1'b0, RstData, 2'd0, 1'b1);
    check_p("rst_p", 1'b0, RstData, 2'd0);
    check("rst_p_ready", 32'(p_in_ready), 32'd1);
    rst = 1'b0;

    // Streaming at full rate: one out per cycle, first one cycle after accept.
    s_in_valid  = 1'b1;
    s_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_in_data = 8'(i);
      tick();
      check_s($sformatf("stream%0d", i), 1'b1, 8'(i), 2'd1, 1'b1);
    end
    s_in_valid = 1'b0;
    tick();
    check_s("stream_drain", 1'b0, RstData, 2'd0, 1'b1);

    // Backpressure fills the skid slot, then drains in order.
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'hA1;
    tick();
    check_s("bp_a1", 1'b1, 8'hA1, 2'd1, 1'b1);
    s_in_data = 8'hA2;
    tick();
    check_s("bp_a2", 1'b1, 8'hA1, 2'd2, 1'b0);
    s_in_data = 8'hA3;
    tick();
    check_s("bp_hold", 1'b1, 8'hA1, 2'd2, 1'b0);
    s_out_ready = 1'b1;
    tick();
    check_s("bp_out_a2", 1'b1, 8'hA2, 2'd1, 1'b1);
    tick();
    check_s("bp_out_a3", 1'b1, 8'hA3, 2'd1, 1'b1);
    s_in_valid = 1'b0;
    tick();
    check_s("bp_empty", 1'b0, RstData, 2'd0, 1'b1);

    // Flush while full, with a pending offer.
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'hB1;
    tick();
    s_in_data = 8'hB2;
    tick();
    check_s("fl_full", 1'b1, 8'hB1, 2'd2, 1'b0);
    s_flush   = 1'b1;
    s_in_data = 8'hB3;
    tick();
    check_s("fl_after", 1'b0, RstData, 2'd0, 1'b1);
    s_flush     = 1'b0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    tick();
    check_s("fl_no_b3", 1'b0, RstData, 2'd0, 1'b1);

    // Flush in ONE discards an accept that would otherwise happen.
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'hF1;
    tick();
    s_flush   = 1'b1;
    s_in_data = 8'hF2;
    tick();
    check_s("fl_one", 1'b0, RstData, 2'd0, 1'b1);
    s_flush    = 1'b0;
    s_in_valid = 1'b0;

    // Reset while full, with flush and offer active.
    s_in_valid = 1'b1;
    s_in_data  = 8'h91;
    tick();
    s_in_data = 8'h92;
    tick();
    check_s("rf_full", 1'b1, 8'h91, 2'd2, 1'b0);
    rst         = 1'b1;
    s_flush     = 1'b1;
    s_out_ready = 1'b1;
    s_in_data   = 8'h93;
    tick();
    check_s("rf_rst", 1'b0, RstData, 2'd0, 1'b1);
    rst         = 1'b0;
    s_flush     = 1'b0;
    s_out_ready = 1'b0;
    s_in_data   = 8'hD1;
    tick();
    check_s("rf_d1", 1'b1, 8'hD1, 2'd1, 1'b1);
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    tick();
    check_s("rf_drain", 1'b0, RstData, 2'd0, 1'b1);
    s_out_ready = 1'b0;

    // SKID=0: simultaneous pop and accept replaces the entry.
    p_in_valid = 1'b1;
    p_in_data  = 8'hC1;
    tick();
    check_p("p_c1", 1'b1, 8'hC1, 2'd1);
    p_in_data = 8'hC2;
    #1;
    check("p_ready_blocked", 32'(p_in_ready), 32'd0);
    p_out_ready = 1'b1;
    #1;
    check("p_ready_comb", 32'(p_in_ready), 32'd1);
    tick();
    check_p("p_c2", 1'b1, 8'hC2, 2'd1);
    p_in_valid = 1'b0;
    tick();
    check_p("p_pop", 1'b0, RstData, 2'd0);
    p_out_ready = 1'b0;
    p_in_valid  = 1'b1;
    p_in_data   = 8'hE1;
    tick();
    check_p("p_e1", 1'b1, 8'hE1, 2'd1);
    p_flush     = 1'b1;
    p_out_ready = 1'b1;
    p_in_data   = 8'hE2;
    tick();
    check_p("p_flush", 1'b0, RstData, 2'd0);
    p_flush     = 1'b0;
    p_in_valid  = 1'b0;
    p_out_ready = 1'b0;

    // Random valid/ready/flush against queue models.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      s_in_valid  = ($urandom_range(0, 1) == 1);
      s_out_ready = ($urandom_range(0, 1) == 1);
      s_flush     = ($urandom_range(0, 9) == 0);
      s_in_data   = 8'($urandom);
      p_in_valid  = ($urandom_range(0, 1) == 1);
      p_out_ready = ($urandom_range(0, 1) == 1);
      p_flush     = ($urandom_range(0, 9) == 0);
      p_in_data   = 8'($urandom);
      #1;
      s_rdy_exp = (sq.size() < 2);
      p_rdy_exp = (pq.size() == 0) || p_out_ready;
      check("rnd_s_ready", 32'(s_in_ready), 32'(s_rdy_exp));
      check("rnd_p_ready", 32'(p_in_ready), 32'(p_rdy_exp));
      s_acc = s_in_valid && s_rdy_exp;
      s_pop = (sq.size() != 0) && s_out_ready;
      p_acc = p_in_valid && p_rdy_exp;
      p_pop = (pq.size() != 0) && p_out_ready;
      tick();
      if (s_flush) begin
        sq.delete();
      end else begin
        if (s_pop) void'(sq.pop_front());
        if (s_acc) sq.push_back(s_in_data);
      end
      if (p_flush) begin
        pq.delete();
      end else begin
        if (p_pop) void'(pq.pop_front());
        if (p_acc) pq.push_back(p_in_data);
      end
      check_s("rnd_s", sq.size() != 0, (sq.size() != 0) ? sq[0] : RstData,
              2'(sq.size()), sq.size() < 2);
      check_p("rnd_p", pq.size() != 0, (pq.size() != 0) ? pq[0] : RstData,
              2'(pq.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
